// File: rtl/shift_tx_sequencer_pkg.sv
// Shared types and helpers for the serial transmit sequencer.
// - state_t     : sequencer FSM encoding (IDLE=0, SHIFT=1, GAP=2)
// - clog2_min1  : counter width helper that never returns a zero width
package shift_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Width needed to count 0..value-1, at least one bit so a
    // degenerate counter still has a legal declaration.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/shift_tx_sequencer_if.sv
// Word-in / bit-out bus of the serial transmit sequencer.
// - in_valid/in_ready/in_data : parallel word handshake from the producer
// - sdo/sdo_valid/sdo_last    : serial stream towards the sink, MSB first
// master = word producer / serial sink side, slave = sequencer side.
interface shift_tx_sequencer_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          sdo;
    logic          sdo_valid;
    logic          sdo_last;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sdo,
        input  sdo_valid,
        input  sdo_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sdo,
        output sdo_valid,
        output sdo_last
    );
endinterface

// File: rtl/shift_tx_sequencer_sreg.sv
// Parallel-load left shift register.
// - clk, rst_n : clock, asynchronous active-low reset
// - sync_rst   : synchronous clear (highest priority)
// - load, d    : parallel load of d (beats shifting)
// - en, data_l : shift left by one, data_l enters at bit 0
// - q          : register contents, q[DW-1] is the outgoing bit
module left_shift_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_rst,
    input  logic          load,
    input  logic          en,
    input  logic          data_l,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // Shift register storage: clear > load > shift > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {DW{1'b0}};
        end else if (sync_rst) begin
            q <= {DW{1'b0}};
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= {q[DW-2:0], data_l};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/shift_tx_sequencer.sv
// Serial transmit sequencer: takes parallel words on a valid/ready handshake
// and shifts each out MSB-first, one bit per clock, with GAP idle cycles
// between frames and a synchronous abort.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : slave side of shift_tx_sequencer_if (word in, serial out)
// - abort      : drop the current frame, clear the shift register
// - busy       : sequencer is not idle
// - word_cnt   : number of completed frames, wrapping
module shift_tx_sequencer
    import shift_tx_pkg::*;
#(
    parameter int DW   = 4,
    parameter int GAP  = 1,
    parameter int CNTW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_tx_sequencer_if.slave bus,
    input  logic                abort,
    output logic                busy,
    output logic [CNTW-1:0]     word_cnt
);

    localparam int BW = clog2_min1(DW);
    localparam int GW = clog2_min1(GAP + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [GW-1:0] LAST_GAP = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};

    state_t          state_r;
    logic [BW-1:0]   bit_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [CNTW-1:0] word_cnt_r;

    logic            last_bit_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            shift_en_s;
    logic [DW-1:0]   q_s;

    // Handshake and shift-register control decode from registered state.
    // With no gap the last-bit cycle also accepts, so frames abut seamlessly.
    always_comb begin
        last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == LAST_BIT);
        shift_en_s = (state_r == ST_SHIFT);
        if (abort) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if ((GAP == 0) && last_bit_s) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid & in_ready_s;
    end

    left_shift_reg #(
        .DW (DW)
    ) u_sreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_rst (abort),
        .load     (accept_s),
        .en       (shift_en_s),
        .data_l   (1'b0),
        .d        (bus.in_data),
        .q        (q_s)
    );

    // Sequencer FSM with bit, gap and completed-frame counters.
    // Abort wins over everything and never credits the frame it cuts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {BW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            word_cnt_r <= {CNTW{1'b0}};
        end else if (abort) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= {BW{1'b0}};
            gap_cnt_r <= {GW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= {BW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        word_cnt_r <= word_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                        bit_cnt_r  <= {BW{1'b0}};
                        if (accept_s) begin
                            state_r <= ST_SHIFT;
                        end else if (GAP > 0) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= {GW{1'b0}};
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == LAST_GAP) begin
                        state_r   <= ST_IDLE;
                        gap_cnt_r <= {GW{1'b0}};
                    end else begin
                        gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= {BW{1'b0}};
                    gap_cnt_r <= {GW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.sdo_valid = (state_r == ST_SHIFT);
    assign bus.sdo       = q_s[DW-1] & (state_r == ST_SHIFT);
    assign bus.sdo_last  = last_bit_s;
    assign busy          = (state_r != ST_IDLE);
    assign word_cnt      = word_cnt_r;

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Bench for shift_tx_sequencer: one instance with a one-cycle gap and one
// with back-to-back frames, checked every cycle against a countdown model
// of "bits still to send / gap cycles still to wait", plus literal checks.
module tb_shift_tx_sequencer;

    localparam int DW   = 4;
    localparam int CNTW = 8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic abort1 = 1'b0;
    logic abort0 = 1'b0;
    logic busy1, busy0;
    logic [CNTW-1:0] wc1, wc0;

    shift_tx_sequencer_if #(.DW(DW)) bus1 ();
    shift_tx_sequencer_if #(.DW(DW)) bus0 ();

    shift_tx_sequencer #(.DW(DW), .GAP(1), .CNTW(CNTW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .abort(abort1), .busy(busy1), .word_cnt(wc1)
    );
    shift_tx_sequencer #(.DW(DW), .GAP(0), .CNTW(CNTW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .abort(abort0), .busy(busy0), .word_cnt(wc0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits left in the current frame and gap cycles left afterwards.
    typedef struct {
        int             rem_bits;
        int             rem_gap;
        logic [DW-1:0]  word;
        logic [CNTW-1:0] cnt;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t m_reset();
        mdl_t r;
        r.rem_bits = 0;
        r.rem_gap  = 0;
        r.word     = '0;
        r.cnt      = '0;
        return r;
    endfunction

    function automatic logic m_ready(input mdl_t m, input int gap, input logic ab);
        if (ab) return 1'b0;
        return ((m.rem_bits == 0) && (m.rem_gap == 0)) || ((gap == 0) && (m.rem_bits == 1));
    endfunction

    function automatic mdl_t m_next(input mdl_t m, input int gap, input logic v,
                                    input logic [DW-1:0] d, input logic ab);
        mdl_t n;
        logic acc;
        n = m;
        if (ab) begin
            n.rem_bits = 0;
            n.rem_gap  = 0;
            return n;
        end
        acc = v && m_ready(m, gap, ab);
        if (m.rem_bits == 1) n.cnt = m.cnt + 1'b1;
        if (acc) begin
            n.rem_bits = DW;
            n.rem_gap  = 0;
            n.word     = d;
        end else if (m.rem_bits > 0) begin
            n.rem_bits = m.rem_bits - 1;
            if (n.rem_bits == 0) n.rem_gap = gap;
        end else if (m.rem_gap > 0) begin
            n.rem_gap = m.rem_gap - 1;
        end
        return n;
    endfunction

    function automatic logic m_sdo(input mdl_t m);
        if (m.rem_bits > 0) return m.word[m.rem_bits-1];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= m_reset();
            m0 <= m_reset();
        end else begin
            m1 <= m_next(m1, 1, bus1.in_valid, bus1.in_data, abort1);
            m0 <= m_next(m0, 0, bus0.in_valid, bus0.in_data, abort0);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready1",  32'(bus1.in_ready),  32'(m_ready(m1, 1, abort1)));
            check("sdo_valid1", 32'(bus1.sdo_valid), 32'(m1.rem_bits > 0));
            check("sdo1",       32'(bus1.sdo),       32'(m_sdo(m1)));
            check("sdo_last1",  32'(bus1.sdo_last),  32'(m1.rem_bits == 1));
            check("busy1",      32'(busy1),          32'((m1.rem_bits > 0) || (m1.rem_gap > 0)));
            check("word_cnt1",  32'(wc1),            32'(m1.cnt));
            check("in_ready0",  32'(bus0.in_ready),  32'(m_ready(m0, 0, abort0)));
            check("sdo_valid0", 32'(bus0.sdo_valid), 32'(m0.rem_bits > 0));
            check("sdo0",       32'(bus0.sdo),       32'(m_sdo(m0)));
            check("sdo_last0",  32'(bus0.sdo_last),  32'(m0.rem_bits == 1));
            check("busy0",      32'(busy0),          32'((m0.rem_bits > 0) || (m0.rem_gap > 0)));
            check("word_cnt0",  32'(wc0),            32'(m0.cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] bits4;
        logic [3:0] got4;
        logic [7:0] got8;
        int frames;
        int n_cyc;
        bit acc0;
        bit hold1, hold0;

        bus1.in_valid = 1'b0; bus1.in_data = 4'h0;
        bus0.in_valid = 1'b0; bus0.in_data = 4'h0;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready",  32'(bus1.in_ready),  32'd1);
        check("rst_sdo",       32'(bus1.sdo),       32'd0);
        check("rst_sdo_valid", 32'(bus1.sdo_valid), 32'd0);
        check("rst_sdo_last",  32'(bus1.sdo_last),  32'd0);
        check("rst_busy",      32'(busy1),          32'd0);
        check("rst_word_cnt",  32'(wc1),            32'd0);

        // GAP=1: single word 1011
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'b1011;
        bits4 = 4'b1011;
        for (int k = 1; k <= 5; k++) begin
            step();
            bus1.in_valid = 1'b0;
            @(negedge clk);
            check("g1_in_ready_low", 32'(bus1.in_ready), 32'd0);
            if (k <= 4) begin
                check("g1_sdo_bit", 32'(bus1.sdo), 32'(bits4[4-k]));
                check("g1_sdo_last", 32'(bus1.sdo_last), 32'(k == 4));
            end
        end
        step();
        @(negedge clk);
        check("g1_word_cnt", 32'(wc1), 32'd1);
        check("g1_ready_again", 32'(bus1.in_ready), 32'd1);
        check("g1_model_cnt", 32'(m1.cnt), 32'd1);

        // GAP=0: A then 5 back-to-back
        step();
        bus0.in_valid = 1'b1;
        bus0.in_data  = 4'hA;
        got8 = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) bus0.in_data = 4'h5;
            if (k == 5) bus0.in_valid = 1'b0;
            @(negedge clk);
            got8 = {got8[6:0], bus0.sdo};
            if ((k == 4) || (k == 8)) check("g0_ready_last_bit", 32'(bus0.in_ready), 32'd1);
        end
        check("g0_stream", 32'(got8), 32'h000000A5);
        step();
        @(negedge clk);
        check("g0_word_cnt", 32'(wc0), 32'd2);

        // Abort after two bits of F, then 9
        step();
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'hF;
        step();
        bus1.in_valid = 1'b0;
        step();
        step();
        abort1 = 1'b1;
        @(negedge clk);
        check("abort_ready_low", 32'(bus1.in_ready), 32'd0);
        step();
        abort1 = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'h9;
        @(negedge clk);
        check("abort_idle_valid", 32'(bus1.sdo_valid), 32'd0);
        check("abort_idle_ready", 32'(bus1.in_ready),  32'd1);
        check("abort_word_cnt",   32'(wc1),            32'd1);
        got4 = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            bus1.in_valid = 1'b0;
            @(negedge clk);
            got4 = {got4[2:0], bus1.sdo};
        end
        check("after_abort_stream", 32'(got4), 32'h9);
        step();
        step();
        @(negedge clk);
        check("after_abort_cnt", 32'(wc1), 32'd2);

        // Abort in IDLE blocks the accept for that cycle only
        step();
        abort1 = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'hD;
        @(negedge clk);
        check("idle_abort_ready", 32'(bus1.in_ready), 32'd0);
        step();
        abort1 = 1'b0;
        @(negedge clk);
        check("idle_abort_not_taken", 32'(bus1.sdo_valid), 32'd0);
        check("idle_abort_ready_back", 32'(bus1.in_ready), 32'd1);
        step();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("idle_abort_taken", 32'(bus1.sdo_valid), 32'd1);
        check("idle_abort_msb", 32'(bus1.sdo), 32'd1);
        repeat (6) step();

        // Asynchronous reset mid-frame, then 3
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'hE;
        step();
        bus1.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        check("async_rst_sdo_valid", 32'(bus1.sdo_valid), 32'd0);
        check("async_rst_sdo",       32'(bus1.sdo),       32'd0);
        check("async_rst_busy",      32'(busy1),          32'd0);
        check("async_rst_ready",     32'(bus1.in_ready),  32'd1);
        check("async_rst_word_cnt",  32'(wc1),            32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'h3;
        got4 = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            bus1.in_valid = 1'b0;
            @(negedge clk);
            got4 = {got4[2:0], bus1.sdo};
        end
        check("post_rst_stream", 32'(got4), 32'h3);
        repeat (3) step();

        // 256 back-to-back frames at GAP=0: counter wraps to 0
        frames = 0;
        n_cyc  = 0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = 4'($urandom);
        while ((frames < 256) && (n_cyc < 3000)) begin
            acc0 = bus0.in_valid && m_ready(m0, 0, abort0);
            step();
            n_cyc++;
            if (acc0) begin
                frames++;
                if (frames < 256) bus0.in_data = 4'($urandom);
                else bus0.in_valid = 1'b0;
            end
        end
        check("wrap_frames", 32'(frames), 32'd256);
        check("wrap_cycles", 32'(n_cyc), 32'd1021);
        repeat (5) step();
        @(negedge clk);
        check("wrap_word_cnt", 32'(wc0), 32'd0);
        check("wrap_model_cnt", 32'(m0.cnt), 32'd0);

        // Randomized traffic with occasional aborts on both instances
        for (int c = 0; c < 1500; c++) begin
            hold1 = bus1.in_valid && !m_ready(m1, 1, abort1);
            hold0 = bus0.in_valid && !m_ready(m0, 0, abort0);
            step();
            if (!hold1) begin
                bus1.in_valid = ($urandom_range(0, 3) != 0);
                bus1.in_data  = 4'($urandom);
            end
            if (!hold0) begin
                bus0.in_valid = ($urandom_range(0, 3) != 0);
                bus0.in_data  = 4'($urandom);
            end
            abort1 = ($urandom_range(0, 19) == 0);
            abort0 = ($urandom_range(0, 19) == 0);
        end
        step();
        bus1.in_valid = 1'b0;
        bus0.in_valid = 1'b0;
        abort1 = 1'b0;
        abort0 = 1'b0;
        repeat (8) step();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
